// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port unified-memory arbiter.
// Owner encoding tags who gets the one-cycle-latency read response.
package mem_arb_pkg;

    localparam int DEF_ADDR_W     = 20;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_STARVE_MAX = 4;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_IF    = 2'd1,
        OWN_DM_RD = 2'd2,
        OWN_DM_WR = 2'd3
    } owner_e;

    function automatic owner_e grant_owner(input logic if_g, input logic dm_g, input logic we);
        if (if_g) begin
            return OWN_IF;
        end
        if (dm_g) begin
            return we ? OWN_DM_WR : OWN_DM_RD;
        end
        return OWN_NONE;
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive cycles the fetch port was denied.
// sat tells the arbiter to hand the next contended cycle to fetch.
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int MAX = DEF_STARVE_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_C)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign sat = (cnt == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Fixed-priority (data first) arbiter for fetch and load/store sharing one
// single-ported memory, with a starvation bound that forces a fetch grant.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,

    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    logic [CNT_W-1:0] starve_cnt;
    logic             starve_sat;
    owner_e           owner;
    owner_e           owner_d;

    arb_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (if_req & ~if_gnt),
        .clr (if_gnt | ~if_req),
        .cnt (starve_cnt),
        .sat (starve_sat)
    );

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/case leaves a signal unassigned and infers a latch.
    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (!rst) begin
            if (if_req && dm_req) begin
                if (starve_sat) begin
                    if_gnt = 1'b1;
                end else begin
                    dm_gnt = 1'b1;
                end
            end else if (if_req) begin
                if_gnt = 1'b1;
            end else if (dm_req) begin
                dm_gnt = 1'b1;
            end
        end
    end

    // A fetch is always a plain full-word read: no write strobes leak through.
    always_comb begin
        mem_req   = if_gnt | dm_gnt;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_addr = if_addr;
        end else if (dm_gnt) begin
            mem_we    = dm_we;
            mem_be    = dm_be;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end
    end

    assign owner_d = grant_owner(if_gnt, dm_gnt, dm_we);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner <= OWN_NONE;
        end else begin
            owner <= owner_d;
        end
    end

    always_comb begin
        if_rvalid = 1'b0;
        if_rdata  = '0;
        dm_rvalid = 1'b0;
        dm_rdata  = '0;
        case (owner)
            OWN_IF: begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end
            OWN_DM_RD: begin
                dm_rvalid = 1'b1;
                dm_rdata  = mem_rdata;
            end
            OWN_DM_WR: begin
                dm_rvalid = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
